// File: rtl/nco_pinc_ctrl.sv
// Sequences NCO phase-increment updates (base + signed loop correction) onto the DDS AXI-S config channel.
// Optional phase-offset half of the config word is enabled by defining NCO_PHASE_OFFSET_EN.
module nco_pinc_ctrl #(
  parameter int PINC_WIDTH  = 32,
  parameter int ADJ_WIDTH   = 16,
  parameter int HOLD_CYCLES = 8,
`ifdef NCO_PHASE_OFFSET_EN
  localparam int CFG_WIDTH  = 2 * PINC_WIDTH
`else
  localparam int CFG_WIDTH  = PINC_WIDTH
`endif
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [PINC_WIDTH-1:0] base_pinc,
  input  logic                  base_load,
  input  logic [ADJ_WIDTH-1:0]  loop_adj,
  input  logic                  loop_valid,
`ifdef NCO_PHASE_OFFSET_EN
  input  logic [PINC_WIDTH-1:0] poff_in,
  input  logic                  poff_load,
`endif
  output logic [CFG_WIDTH-1:0]  cfg_tdata,
  output logic                  cfg_tvalid,
  input  logic                  cfg_tready,
  output logic [PINC_WIDTH-1:0] pinc_cur,
  output logic                  busy,
  output logic                  adj_drop
);

  localparam int HCW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, SEND, HOLD} state_t;

  state_t                state, state_nxt;
  logic [PINC_WIDTH-1:0] base_reg, base_nxt;
  logic [ADJ_WIDTH-1:0]  adj_reg, adj_nxt;
  logic                  pending, pending_nxt;
  logic                  adj_unsent, adj_unsent_nxt;
  logic [HCW-1:0]        hold_cnt, hold_nxt;
  logic [CFG_WIDTH-1:0]  tdata_nxt, cfg_word;
  logic                  tvalid_nxt, adj_drop_nxt;
  logic [PINC_WIDTH-1:0] pinc_nxt, target;
  logic                  capture, pend_cap, load_send;

`ifdef NCO_PHASE_OFFSET_EN
  logic [PINC_WIDTH-1:0] poff_reg, poff_nxt;
  assign poff_nxt = poff_load ? poff_in : poff_reg;
  assign capture  = base_load | loop_valid | poff_load;
  assign cfg_word = {poff_nxt, target};
`else
  assign capture  = base_load | loop_valid;
  assign cfg_word = target;
`endif

  assign base_nxt = base_load  ? base_pinc : base_reg;
  assign adj_nxt  = loop_valid ? loop_adj  : adj_reg;
  // Target uses this cycle's captures so a request from IDLE sends the new values.
  assign target   = base_nxt + {{(PINC_WIDTH-ADJ_WIDTH){adj_nxt[ADJ_WIDTH-1]}}, adj_nxt};
  assign pend_cap = pending | capture;
  assign busy     = (state != IDLE);

  always_comb begin
    state_nxt      = state;
    pending_nxt    = pend_cap;
    adj_unsent_nxt = adj_unsent | loop_valid;
    hold_nxt       = hold_cnt;
    tdata_nxt      = cfg_tdata;
    tvalid_nxt     = cfg_tvalid;
    pinc_nxt       = pinc_cur;
    load_send      = 1'b0;
    adj_drop_nxt   = loop_valid & pending & adj_unsent;

    unique case (state)
      IDLE: load_send = pend_cap;
      SEND: begin
        if (cfg_tready) begin
          pinc_nxt   = cfg_tdata[PINC_WIDTH-1:0];
          tvalid_nxt = 1'b0;
          if (HOLD_CYCLES == 0) begin
            if (pend_cap) load_send = 1'b1;
            else          state_nxt = IDLE;
          end else begin
            state_nxt = HOLD;
            hold_nxt  = HCW'(HOLD_CYCLES - 1);
          end
        end
      end
      HOLD: begin
        if (hold_cnt == '0) begin
          if (pend_cap) load_send = 1'b1;
          else          state_nxt = IDLE;
        end else begin
          hold_nxt = hold_cnt - 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (load_send) begin
      state_nxt      = SEND;
      tdata_nxt      = cfg_word;
      tvalid_nxt     = 1'b1;
      pending_nxt    = 1'b0;
      adj_unsent_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      base_reg   <= '0;
      adj_reg    <= '0;
      pending    <= 1'b0;
      adj_unsent <= 1'b0;
      hold_cnt   <= '0;
      cfg_tdata  <= '0;
      cfg_tvalid <= 1'b0;
      pinc_cur   <= '0;
      adj_drop   <= 1'b0;
    end else begin
      state      <= state_nxt;
      base_reg   <= base_nxt;
      adj_reg    <= adj_nxt;
      pending    <= pending_nxt;
      adj_unsent <= adj_unsent_nxt;
      hold_cnt   <= hold_nxt;
      cfg_tdata  <= tdata_nxt;
      cfg_tvalid <= tvalid_nxt;
      pinc_cur   <= pinc_nxt;
      adj_drop   <= adj_drop_nxt;
    end
  end

`ifdef NCO_PHASE_OFFSET_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) poff_reg <= '0;
    else        poff_reg <= poff_nxt;
  end
`endif

endmodule

// File: tb/tb_nco_pinc_ctrl.sv
// Directed self-checking bench for nco_pinc_ctrl (HOLD_CYCLES=8); exercises the
// phase-offset word too when NCO_PHASE_OFFSET_EN is defined.
module tb_nco_pinc_ctrl;

`ifdef NCO_PHASE_OFFSET_EN
  localparam int CW = 64;
`else
  localparam int CW = 32;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [31:0]   base_pinc;
  logic          base_load;
  logic [15:0]   loop_adj;
  logic          loop_valid;
  logic [CW-1:0] cfg_tdata;
  logic          cfg_tvalid;
  logic          cfg_tready;
  logic [31:0]   pinc_cur;
  logic          busy;
  logic          adj_drop;
`ifdef NCO_PHASE_OFFSET_EN
  logic [31:0]   poff_in;
  logic          poff_load;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  nco_pinc_ctrl #(.PINC_WIDTH(32), .ADJ_WIDTH(16), .HOLD_CYCLES(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .base_pinc  (base_pinc),
    .base_load  (base_load),
    .loop_adj   (loop_adj),
    .loop_valid (loop_valid),
`ifdef NCO_PHASE_OFFSET_EN
    .poff_in    (poff_in),
    .poff_load  (poff_load),
`endif
    .cfg_tdata  (cfg_tdata),
    .cfg_tvalid (cfg_tvalid),
    .cfg_tready (cfg_tready),
    .pinc_cur   (pinc_cur),
    .busy       (busy),
    .adj_drop   (adj_drop)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 20 && busy; i++) tick();
    chk(tag, 64'(busy), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0; base_pinc = '0; base_load = 1'b0; loop_adj = '0;
    loop_valid = 1'b0; cfg_tready = 1'b0;
`ifdef NCO_PHASE_OFFSET_EN
    poff_in = '0; poff_load = 1'b0;
`endif
    tick(); tick();
    chk("rst_tdata", 64'(cfg_tdata), 64'd0);
    chk("rst_tvalid", 64'(cfg_tvalid), 64'd0);
    chk("rst_pinc", 64'(pinc_cur), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_drop", 64'(adj_drop), 64'd0);
    rst_n = 1'b1;
    tick();

    // 1: single base load, ready high
    cfg_tready = 1'b1;
    base_pinc = 32'h0CCCCCCD; base_load = 1'b1;
    tick(); base_load = 1'b0;
    chk("t1_tvalid", 64'(cfg_tvalid), 64'd1);
    chk("t1_tdata", 64'(cfg_tdata[31:0]), 64'h0CCCCCCD);
    chk("t1_pinc_before", 64'(pinc_cur), 64'd0);
    tick();
    chk("t1_pinc", 64'(pinc_cur), 64'h0CCCCCCD);
    chk("t1_tvalid_low", 64'(cfg_tvalid), 64'd0);
    for (int i = 0; i < 7; i++) begin
      chk("t1_hold_busy", 64'(busy), 64'd1);
      tick();
    end
    chk("t1_hold_last", 64'(busy), 64'd1);
    tick();
    chk("t1_idle", 64'(busy), 64'd0);

    // 2: backpressure, loop_adj captured during SEND
    cfg_tready = 1'b0;
    base_load = 1'b1;
    tick(); base_load = 1'b0;
    chk("t2_tvalid", 64'(cfg_tvalid), 64'd1);
    loop_adj = 16'sd100; loop_valid = 1'b1;
    tick(); loop_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("t2_stable_data", 64'(cfg_tdata[31:0]), 64'h0CCCCCCD);
      chk("t2_stable_valid", 64'(cfg_tvalid), 64'd1);
      tick();
    end
    cfg_tready = 1'b1;
    tick();
    chk("t2_pinc", 64'(pinc_cur), 64'h0CCCCCCD);
    for (int i = 0; i < 7; i++) tick();
    chk("t2_hold_valid", 64'(cfg_tvalid), 64'd0);
    chk("t2_hold_busy", 64'(busy), 64'd1);
    tick();
    chk("t2_b2b_valid", 64'(cfg_tvalid), 64'd1);
    chk("t2_b2b_data", 64'(cfg_tdata[31:0]), 64'h0CCCCD31);
    tick();
    chk("t2_pinc2", 64'(pinc_cur), 64'h0CCCCD31);
    wait_idle("t2_idle");

    // 3: wrap in both directions
    base_pinc = 32'h0; base_load = 1'b1; loop_adj = 16'hFFFF; loop_valid = 1'b1;
    tick(); base_load = 1'b0; loop_valid = 1'b0;
    chk("t3_wrap_neg", 64'(cfg_tdata[31:0]), 64'hFFFFFFFF);
    tick();
    wait_idle("t3_idle_a");
    base_pinc = 32'h1; base_load = 1'b1;
    tick(); base_load = 1'b0;
    chk("t3_wrap_zero", 64'(cfg_tdata[31:0]), 64'h0);
    chk("t3_wrap_valid", 64'(cfg_tvalid), 64'd1);
    tick();
    wait_idle("t3_idle_b");

    // 4: three corrections during HOLD
    base_pinc = 32'h10000000; base_load = 1'b1;
    tick(); base_load = 1'b0;
    chk("t4_first", 64'(cfg_tdata[31:0]), 64'h0FFFFFFF);
    tick();
    loop_adj = 16'sd10; loop_valid = 1'b1;
    tick(); loop_valid = 1'b0;
    chk("t4_drop0", 64'(adj_drop), 64'd0);
    tick();
    loop_adj = 16'sd20; loop_valid = 1'b1;
    tick(); loop_valid = 1'b0;
    chk("t4_drop1", 64'(adj_drop), 64'd1);
    tick();
    chk("t4_drop1_end", 64'(adj_drop), 64'd0);
    loop_adj = 16'sd30; loop_valid = 1'b1;
    tick(); loop_valid = 1'b0;
    chk("t4_drop2", 64'(adj_drop), 64'd1);
    tick();
    chk("t4_no_early", 64'(cfg_tvalid), 64'd0);
    tick(); tick();
    chk("t4_send_valid", 64'(cfg_tvalid), 64'd1);
    chk("t4_send_data", 64'(cfg_tdata[31:0]), 64'h1000001E);
    tick();
    wait_idle("t4_idle");
    tick();
    chk("t4_single", 64'(cfg_tvalid), 64'd0);

    // 5: simultaneous capture from IDLE
    base_pinc = 32'h20000000; base_load = 1'b1; loop_adj = 16'hFFFB; loop_valid = 1'b1;
    tick(); base_load = 1'b0; loop_valid = 1'b0;
    chk("t5_data", 64'(cfg_tdata[31:0]), 64'h1FFFFFFB);
    chk("t5_drop", 64'(adj_drop), 64'd0);
    tick();
    chk("t5_pinc", 64'(pinc_cur), 64'h1FFFFFFB);
    wait_idle("t5_idle");
    tick(); tick();
    chk("t5_single", 64'(cfg_tvalid), 64'd0);

    // 6: asynchronous reset during SEND
    cfg_tready = 1'b0;
    base_pinc = 32'h30000000; base_load = 1'b1;
    tick(); base_load = 1'b0;
    chk("t6_send", 64'(cfg_tdata[31:0]), 64'h2FFFFFFB);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_valid", 64'(cfg_tvalid), 64'd0);
    chk("t6_async_busy", 64'(busy), 64'd0);
    tick(); rst_n = 1'b1; cfg_tready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t6_quiet", 64'(cfg_tvalid), 64'd0);
    end
    base_pinc = 32'h5; base_load = 1'b1;
    tick(); base_load = 1'b0;
    chk("t6_new", 64'(cfg_tdata[31:0]), 64'h5);
    tick();
    wait_idle("t6_idle");

`ifdef NCO_PHASE_OFFSET_EN
    poff_in = 32'h40000000; poff_load = 1'b1;
    tick(); poff_load = 1'b0;
    chk("poff_hi", 64'(cfg_tdata[63:32]), 64'h40000000);
    chk("poff_lo", 64'(cfg_tdata[31:0]), 64'h5);
    tick();
    wait_idle("poff_idle");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
